sprite_line_scheduler: RTL and testbench
========================================

Name: sprite_line_scheduler

Overview:
- Per-scanline sprite evaluator running in the 100 MHz sprite compute domain.
- On each line-start pulse it walks the 64-entry sprite RAM through its read port, picks up to 8 sprites whose vertical span covers the target line, and writes them into the 8 tile-draw slot registers.
- Reports the hit count, valid mask and an overflow flag. It is the sequencer that feeds the eight tile-draw engines.

Parameters:
- SPRITE_NUM, 64: number of sprite RAM entries.
- SLOT_NUM, 8: number of draw slots per line.
- SPRITE_H, 16: sprite height in lines.
- Y_BIT, 10: width of the line coordinate.

Ports:
- clk, in, 1: 100 MHz compute clock.
- rstn, in, 1: reset, asynchronous, active-low.
- line_start, in, 1: one-cycle pulse requesting evaluation for line_y.
- line_y, in, Y_BIT: target scanline. Sampled on line_start.
- game_window, in, 1: game area active. Sampled on line_start.
- frame_start, in, 1: one-cycle pulse at frame start.
- ram_rdaddr, out, 6: sprite RAM read address.
- ram_rdata, in, 32: sprite RAM data, valid exactly 1 cycle after address.
- slot_we, out, 1: slot write strobe.
- slot_idx, out, 3: slot being written.
- slot_data, out, 32: entry written to the slot (raw RAM word, or 0 when clearing).
- slot_valid, out, SLOT_NUM: per-slot valid mask for the current evaluation.
- hit_cnt, out, 4: sprites selected, 0..8.
- overflow, out, 1: more than SLOT_NUM hits on this line.
- busy, out, 1: evaluation in progress.
- line_done, out, 1: one-cycle pulse when the slots are final.

Behaviour:
- Reset is asynchronous and active-low on rstn; all logic is clocked by clk. Reset values: all outputs 0, state IDLE, internal counters 0.
- Entry format:
  - [7:0] X
  - [15:8] Y
  - [23:16] tile
  - [31:24] attr, where attr[7] = enable
- Hit rule: enable=1 AND (line_y − Y), computed in Y_BIT+1 bits with Y zero-extended, is non-negative and less than SPRITE_H. A sprite with Y > line_y is never a hit; there is no wrap.
- States:
  - IDLE: waits for line_start. On line_start, latch line_y and game_window, then go to CLEAR; busy=1.
  - CLEAR: 8 cycles. slot_we=1, slot_idx=0..7, slot_data=0. slot_valid, hit_cnt and overflow are cleared on entry. Next state: SCAN if the latched game_window=1, else FIN.
  - SCAN:
    - Issues ram_rdaddr = (base + k) mod 64 for k = 0..63, one per cycle; base = 0 unless the optional feature is enabled.
    - Evaluates ram_rdata one cycle after each address (pipeline depth 1, tagged with a valid bit).
    - Each hit while hit_cnt < 8: slot_we=1, slot_idx=hit_cnt, slot_data=ram_rdata, slot_valid[hit_cnt] set, hit_cnt increments. Priority order is scan order.
    - A hit with hit_cnt = 8: overflow=1, stop issuing addresses, go to FIN.
    - After the last address's data has been evaluated: go to FIN.
    - Worst case 8 + 64 + 1 + 1 cycles from line_start to line_done.
  - FIN: line_done=1 for one cycle, busy=0, return to IDLE. slot_valid, hit_cnt and overflow hold until the next CLEAR.
- Boundary conditions:
  - line_start while busy: abort, latch the new line_y, restart at CLEAR. No line_done is produced for the aborted line.
  - line_start in the same cycle as the FIN transition: line_done is still emitted, and the new evaluation starts the next cycle.
  - frame_start is ignored in every state when the optional feature is off.
  - ram_rdaddr holds its last value outside SCAN.
  - Exactly 8 hits with no 9th: overflow stays 0 and all 64 entries are scanned.

Optional Feature:
- Macro: SPRITE_SCAN_ROTATE_EN.
- Defined:
  - An internal 6-bit base register is reset to 0.
  - On each frame_start, base advances by 1 (mod 64) if overflow occurred on any line in the previous frame (sticky flag, cleared on frame_start).
  - SCAN starts at base, rotating priority so the dropped sprites vary frame to frame.
  - base is not updated while busy: a frame_start received while busy is deferred to the next IDLE cycle.
- Undefined: base is constant 0, frame_start is unused, and priority is fixed to index order.

Test Plan:
- Reset mid-SCAN (rstn low at scan cycle 20) -> all outputs 0 immediately; the next line_start behaves normally.
- Entries 3, 10, 40 with Y=100, enabled; line_y=105 -> slots 0..2 = entries 3, 10, 40; slot_valid=8'h07; hit_cnt=3; overflow=0; line_done at cycle 74.
- Boundaries: entry Y=100 with line_y=99, 100, 115, 116 -> hit only for 100 and 115. Entry Y=200 with line_y=5 -> no hit. Enabled=0 -> no hit.
- Ten enabled entries (indices 0..9) all covering line 50 -> slots hold entries 0..7, overflow=1, scan stops after index 8 has been evaluated, hit_cnt=8.
- line_start at CLEAR cycle 4, then a second line_start for line 60 during SCAN -> one line_done only; slot contents reflect line 60.
- game_window=0 at line_start -> 8 clear writes, no RAM reads, slot_valid=0, line_done at cycle 9.
- With SPRITE_SCAN_ROTATE_EN, the overflow case above followed by frame_start -> the next line's slots start with entry 1; no overflow in a frame -> base unchanged.

Source files
------------

// File: rtl/sprite_line_scheduler.sv
// sprite_line_scheduler: per-line sprite evaluator feeding the tile-draw slots.
// Optional SPRITE_SCAN_ROTATE_EN rotates the scan start after overflow frames.
module sprite_line_scheduler #(
  parameter int SPRITE_NUM = 64,
  parameter int SLOT_NUM   = 8,
  parameter int SPRITE_H   = 16,
  parameter int Y_BIT      = 10
) (
  input  logic                            clk,
  input  logic                            rstn,
  input  logic                            line_start,
  input  logic [Y_BIT-1:0]                line_y,
  input  logic                            game_window,
  input  logic                            frame_start,
  output logic [$clog2(SPRITE_NUM)-1:0]   ram_rdaddr,
  input  logic [31:0]                     ram_rdata,
  output logic                            slot_we,
  output logic [$clog2(SLOT_NUM)-1:0]     slot_idx,
  output logic [31:0]                     slot_data,
  output logic [SLOT_NUM-1:0]             slot_valid,
  output logic [$clog2(SLOT_NUM+1)-1:0]   hit_cnt,
  output logic                            overflow,
  output logic                            busy,
  output logic                            line_done
);

  localparam int AW = $clog2(SPRITE_NUM);
  localparam int SW = $clog2(SLOT_NUM);
  localparam int HW = $clog2(SLOT_NUM + 1);
  localparam int CW = AW + 1;
  localparam int YW = Y_BIT + 1;

  localparam logic [CW-1:0] SCAN_LEN  = CW'(SPRITE_NUM);
  localparam logic [CW-1:0] SCAN_LAST = CW'(SPRITE_NUM - 1);
  localparam logic [CW-1:0] CLR_LAST  = CW'(SLOT_NUM - 1);
  localparam logic [HW-1:0] FULL      = HW'(SLOT_NUM);
  localparam logic [YW-1:0] SPR_H     = YW'(SPRITE_H);

  typedef enum logic [1:0] {
    IDLE,
    CLEAR,
    SCAN,
    FIN
  } state_t;

  state_t            state;
  state_t            next;
  logic [CW-1:0]     cnt;
  logic [Y_BIT-1:0]  y_q;
  logic              win_q;
  logic              pv;
  logic [AW-1:0]     base;
  logic [YW-1:0]     dy;
  logic              hit;
  logic              full;
  logic              take;
  logic              ovf_hit;
  logic              scan_end;

  // dy goes negative (msb set) when the sprite starts below the line
  assign dy       = {1'b0, y_q} - {{(Y_BIT-7){1'b0}}, ram_rdata[15:8]};
  assign hit      = pv && ram_rdata[31] && !dy[Y_BIT] && (dy < SPR_H);
  assign full     = (hit_cnt == FULL);
  assign take     = (state == SCAN) && hit && !full;
  assign ovf_hit  = (state == SCAN) && hit && full;
  assign scan_end = (cnt == SCAN_LEN);

`ifdef SPRITE_SCAN_ROTATE_EN
  logic ovf_seen;
  logic fs_pend;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      base     <= '0;
      ovf_seen <= 1'b0;
      fs_pend  <= 1'b0;
    end else if (state == IDLE && (frame_start || fs_pend)) begin
      base     <= base + AW'(ovf_seen);
      ovf_seen <= 1'b0;
      fs_pend  <= 1'b0;
    end else begin
      if (frame_start)
        fs_pend <= 1'b1;
      if (ovf_hit && !line_start)
        ovf_seen <= 1'b1;
    end
  end
`else
  logic unused_fs;
  assign base      = '0;
  assign unused_fs = frame_start;
`endif

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn)
      state <= IDLE;
    else
      state <= next;
  end

  always_comb begin
    next = state;
    unique case (state)
      IDLE:  next = IDLE;
      CLEAR: if (cnt == CLR_LAST)
               next = win_q ? SCAN : FIN;
      SCAN:  if (ovf_hit || scan_end)
               next = FIN;
      FIN:   next = IDLE;
    endcase
    if (line_start)
      next = CLEAR;
  end

  always_comb begin
    busy      = 1'b0;
    line_done = 1'b0;
    slot_we   = 1'b0;
    slot_idx  = '0;
    slot_data = '0;
    unique case (state)
      IDLE: ;
      CLEAR: begin
        busy     = 1'b1;
        slot_we  = 1'b1;
        slot_idx = cnt[SW-1:0];
      end
      SCAN: begin
        busy = 1'b1;
        if (take) begin
          slot_we   = 1'b1;
          slot_idx  = hit_cnt[SW-1:0];
          slot_data = ram_rdata;
        end
      end
      FIN: line_done = 1'b1;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      y_q        <= '0;
      win_q      <= 1'b0;
      cnt        <= '0;
      pv         <= 1'b0;
      ram_rdaddr <= '0;
      slot_valid <= '0;
      hit_cnt    <= '0;
      overflow   <= 1'b0;
    end else if (line_start) begin
      y_q        <= line_y;
      win_q      <= game_window;
      cnt        <= '0;
      pv         <= 1'b0;
      slot_valid <= '0;
      hit_cnt    <= '0;
      overflow   <= 1'b0;
    end else begin
      case (state)
        CLEAR: begin
          cnt <= cnt + 1'b1;
          if (cnt == CLR_LAST) begin
            cnt <= '0;
            if (win_q)
              ram_rdaddr <= base;
          end
        end
        SCAN: begin
          pv <= !scan_end && !ovf_hit;
          if (!scan_end && !ovf_hit) begin
            cnt <= cnt + 1'b1;
            if (cnt != SCAN_LAST)
              ram_rdaddr <= ram_rdaddr + 1'b1;
          end
          if (take) begin
            slot_valid[hit_cnt[SW-1:0]] <= 1'b1;
            hit_cnt <= hit_cnt + 1'b1;
          end
          if (ovf_hit)
            overflow <= 1'b1;
        end
        default: pv <= 1'b0;
      endcase
    end
  end

endmodule

// File: tb/tb_sprite_line_scheduler.sv
// tb_sprite_line_scheduler: vector table plus hand sequences for aborts,
// reset and frame_start, with a slot-write scoreboard against a RAM model.
module tb_sprite_line_scheduler;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        line_start = 1'b0;
  logic [9:0]  line_y = '0;
  logic        game_window = 1'b0;
  logic        frame_start = 1'b0;
  logic [5:0]  ram_rdaddr;
  logic [31:0] ram_rdata = '0;
  logic        slot_we;
  logic [2:0]  slot_idx;
  logic [31:0] slot_data;
  logic [7:0]  slot_valid;
  logic [3:0]  hit_cnt;
  logic        overflow;
  logic        busy;
  logic        line_done;

  sprite_line_scheduler dut (
    .clk(clk), .rstn(rstn), .line_start(line_start), .line_y(line_y),
    .game_window(game_window), .frame_start(frame_start),
    .ram_rdaddr(ram_rdaddr), .ram_rdata(ram_rdata), .slot_we(slot_we),
    .slot_idx(slot_idx), .slot_data(slot_data), .slot_valid(slot_valid),
    .hit_cnt(hit_cnt), .overflow(overflow), .busy(busy),
    .line_done(line_done)
  );

  always #5 clk = ~clk;

  logic [31:0] mem [64];
  always @(posedge clk) ram_rdata <= mem[ram_rdaddr];

  typedef struct {
    logic [63:0] en;
    logic [63:0] dis;
    logic [7:0]  y;
    logic [9:0]  ly;
    bit          win;
    int          cnt;
    logic [7:0]  vld;
    bit          ovf;
    int          lat;
  } vec_t;

  vec_t        vt [11];
  logic [34:0] sbq [$];
  logic [34:0] exp_w;
  int          total = 0;
  int          bad = 0;
  bit          sb_on = 1'b1;
  int          done_cnt = 0;
  int          rd_moves = 0;
  logic [5:0]  prev_addr = '0;
  int          base_exp = 0;
  bit          ovf_frame = 1'b0;
  int          m_cnt;
  logic [7:0]  m_vld;
  bit          m_ovf;
  int          m_lat;

  task automatic chk(input string nm, input longint act, input longint exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s act=%0h exp=%0h t=%0t", nm, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (rstn && sb_on && slot_we) begin
      if (sbq.size() == 0)
        chk("extra_write", 1, 0);
      else begin
        exp_w = sbq.pop_front();
        chk("slot_write", {slot_idx, slot_data}, exp_w);
      end
    end
    if (line_done)
      done_cnt++;
    if (ram_rdaddr != prev_addr)
      rd_moves++;
    prev_addr = ram_rdaddr;
  end

  task automatic load(input logic [63:0] en, input logic [63:0] dis,
                      input logic [7:0] y);
    for (int i = 0; i < 64; i++) begin
      if (en[i])
        mem[i] = {1'b1, 7'(i), 8'(i + 100), y, 8'(3 * i)};
      else if (dis[i])
        mem[i] = {1'b0, 7'(i), 8'(i), y, 8'(i)};
      else
        mem[i] = '0;
    end
  endtask

  // Reference: 8 clear writes, then hits in scan order from base_exp
  task automatic model(input logic [9:0] ly, input bit win);
    int hits;
    int idx;
    int y;
    logic [31:0] w;
    for (int i = 0; i < 8; i++)
      sbq.push_back({3'(i), 32'h0});
    m_cnt = 0;
    m_vld = '0;
    m_ovf = 1'b0;
    m_lat = 9;
    if (!win)
      return;
    m_lat = 74;
    hits = 0;
    for (int k = 0; k < 64; k++) begin
      idx = (base_exp + k) % 64;
      w = mem[idx];
      y = int'(w[15:8]);
      if (w[31] && int'(ly) >= y && int'(ly) - y < 16) begin
        if (hits < 8) begin
          sbq.push_back({3'(hits), w});
          m_vld[hits] = 1'b1;
          hits++;
        end else begin
          m_ovf = 1'b1;
          m_lat = 11 + k;
          break;
        end
      end
    end
    m_cnt = hits;
    if (m_ovf)
      ovf_frame = 1'b1;
  endtask

  task automatic start_line(input logic [9:0] ly, input bit win);
    line_start = 1'b1;
    line_y = ly;
    game_window = win;
    @(posedge clk);
    #1;
    line_start = 1'b0;
  endtask

  task automatic wait_done(output int lat);
    int n;
    n = 1;
    while (!line_done && n < 300) begin
      @(posedge clk);
      #1;
      n++;
    end
    lat = line_done ? n : -1;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic run_vec(input vec_t v);
    int lat;
    int mv0;
    load(v.en, v.dis, v.y);
    model(v.ly, v.win);
    mv0 = rd_moves;
    start_line(v.ly, v.win);
    wait_done(lat);
    chk("latency", lat, v.lat);
    chk("hit_cnt", hit_cnt, v.cnt);
    chk("slot_valid", slot_valid, v.vld);
    chk("overflow", overflow, v.ovf);
    chk("busy_fin", busy, 0);
    chk("writes_left", sbq.size(), 0);
    if (!v.win)
      chk("rd_moves", rd_moves - mv0, 0);
    step();
    chk("done_pulse", line_done, 0);
  endtask

  task automatic run_model(input logic [9:0] ly, input bit win);
    int lat;
    model(ly, win);
    start_line(ly, win);
    wait_done(lat);
    chk("m_latency", lat, m_lat);
    chk("m_hit_cnt", hit_cnt, m_cnt);
    chk("m_slot_valid", slot_valid, m_vld);
    chk("m_overflow", overflow, m_ovf);
    chk("m_writes_left", sbq.size(), 0);
    step();
  endtask

  task automatic frame_pulse();
    frame_start = 1'b1;
    step();
    frame_start = 1'b0;
`ifdef SPRITE_SCAN_ROTATE_EN
    if (ovf_frame)
      base_exp = (base_exp + 1) % 64;
`endif
    ovf_frame = 1'b0;
  endtask

  initial begin
    int lat;
    int d0;

    vt[0]  = '{64'h0000_0100_0000_0408, 64'h0, 8'd100, 10'd105, 1'b1, 3, 8'h07, 1'b0, 74};
    vt[1]  = '{64'h20, 64'h0, 8'd100, 10'd99,  1'b1, 0, 8'h00, 1'b0, 74};
    vt[2]  = '{64'h20, 64'h0, 8'd100, 10'd100, 1'b1, 1, 8'h01, 1'b0, 74};
    vt[3]  = '{64'h20, 64'h0, 8'd100, 10'd115, 1'b1, 1, 8'h01, 1'b0, 74};
    vt[4]  = '{64'h20, 64'h0, 8'd100, 10'd116, 1'b1, 0, 8'h00, 1'b0, 74};
    vt[5]  = '{64'h20, 64'h0, 8'd200, 10'd5,   1'b1, 0, 8'h00, 1'b0, 74};
    vt[6]  = '{64'h0,  64'h80, 8'd100, 10'd100, 1'b1, 0, 8'h00, 1'b0, 74};
    vt[7]  = '{64'h3FF, 64'h0, 8'd40, 10'd50,  1'b1, 8, 8'hFF, 1'b1, 19};
    vt[8]  = '{64'h0202_0202_0202_0202, 64'h0, 8'd0, 10'd15, 1'b1, 8, 8'hFF, 1'b0, 74};
    vt[9]  = '{64'h0000_0100_0000_0408, 64'h0, 8'd100, 10'd105, 1'b0, 0, 8'h00, 1'b0, 9};
    vt[10] = '{64'h8000_0000_0000_0000, 64'h0, 8'd30, 10'd30, 1'b1, 1, 8'h01, 1'b0, 74};

    load(64'h0, 64'h0, 8'd0);
    repeat (3) @(posedge clk);
    #1;
    chk("reset_outs", {busy, slot_we, slot_idx, slot_data, slot_valid,
                       hit_cnt, overflow, line_done, ram_rdaddr}, 0);
    rstn = 1'b1;
    step();
    chk("idle_outs", {busy, slot_we, slot_valid, hit_cnt, overflow,
                      line_done}, 0);

    for (int i = 0; i < 11; i++)
      run_vec(vt[i]);

    // Reset at scan cycle 20, then a normal line
    load(vt[0].en, vt[0].dis, vt[0].y);
    model(10'd105, 1'b1);
    start_line(10'd105, 1'b1);
    repeat (28) step();
    chk("pre_reset_hits", hit_cnt, 2);
    rstn = 1'b0;
    #1;
    chk("midscan_reset", {busy, slot_we, slot_idx, slot_data, slot_valid,
                          hit_cnt, overflow, line_done, ram_rdaddr}, 0);
    sbq.delete();
    ovf_frame = 1'b0;
    step();
    step();
    rstn = 1'b1;
    step();
    run_vec(vt[0]);

    // Restart in CLEAR, then again in SCAN for line 60
    load(vt[0].en, vt[0].dis, vt[0].y);
    mem[20] = {8'h80, 8'd20, 8'd55, 8'd7};
    mem[21] = {8'h81, 8'd21, 8'd55, 8'd9};
    sb_on = 1'b0;
    sbq.delete();
    d0 = done_cnt;
    start_line(10'd105, 1'b1);
    repeat (3) step();
    start_line(10'd105, 1'b1);
    repeat (20) step();
    start_line(10'd60, 1'b1);
    sbq.delete();
    model(10'd60, 1'b1);
    sb_on = 1'b1;
    wait_done(lat);
    chk("abort_latency", lat, 74);
    chk("abort_hit_cnt", hit_cnt, 2);
    chk("abort_valid", slot_valid, 8'h03);
    chk("abort_writes_left", sbq.size(), 0);
    step();
    chk("abort_done_count", done_cnt - d0, 1);

    // line_start arriving in the FIN cycle
    load(vt[0].en, vt[0].dis, vt[0].y);
    model(10'd105, 1'b0);
    start_line(10'd105, 1'b0);
    wait_done(lat);
    chk("fin_first_latency", lat, 9);
    d0 = done_cnt;
    model(10'd105, 1'b1);
    start_line(10'd105, 1'b1);
    chk("fin_done_kept", done_cnt - d0, 1);
    chk("fin_restart_busy", busy, 1);
    wait_done(lat);
    chk("fin_second_latency", lat, 74);
    chk("fin_second_hits", hit_cnt, 3);
    step();

    // frame_start: fixed priority by default, rotation when enabled
    frame_pulse();
    load(64'h3FF, 64'h0, 8'd40);
    run_model(10'd50, 1'b1);
    frame_pulse();
    run_model(10'd50, 1'b1);
    frame_pulse();
    load(vt[0].en, vt[0].dis, vt[0].y);
    run_model(10'd105, 1'b1);
    frame_pulse();
    load(64'h3FF, 64'h0, 8'd40);
    run_model(10'd50, 1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
